// File: rtl/dr_adder_pipe_pkg.sv
// Dual-rail (NCL) code points and the threshold/hysteresis primitives shared by the adder slices.
// Pure declarations and functions; no state, no latency, no backpressure.
package ncl_pkg;

    typedef logic [1:0] dr_t;

    localparam dr_t DR_NULL = 2'b00;
    localparam dr_t DR_0    = 2'b01;
    localparam dr_t DR_1    = 2'b10;

    function automatic logic is_data(input dr_t d);
        return (d == DR_0) || (d == DR_1);
    endfunction

    function automatic logic is_illegal(input dr_t d);
        return d == 2'b11;
    endfunction

    // Registered hysteresis cell: set wins, then clear, otherwise hold.
    function automatic logic hyst(input logic q, input logic set, input logic clr);
        return set ? 1'b1 : (clr ? 1'b0 : q);
    endfunction

    function automatic logic th23(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // w carries weight 2, threshold 3.
    function automatic logic th34w2(input logic w, input logic x, input logic y, input logic z);
        return (w & (x | y | z)) | (x & y & z);
    endfunction

endpackage

// File: rtl/dr_adder_pipe_if.sv
// Operand, result and completion bundle of the dual-rail ripple adder.
// master = upstream/downstream environment, slave = the adder.
interface dr_adder_pipe_if
    import ncl_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [2*WIDTH-1:0] a_dr;
    logic [2*WIDTH-1:0] b_dr;
    dr_t                cin_dr;
    logic               in_comp;
    logic [2*WIDTH-1:0] sum_dr;
    logic               sum_comp;
    dr_t                cout_dr;
    logic               cout_comp;
    logic               code_err;

    modport master (
        output a_dr, b_dr, cin_dr, sum_comp, cout_comp,
        input  in_comp, sum_dr, cout_dr, code_err
    );

    modport slave (
        input  a_dr, b_dr, cin_dr, sum_comp, cout_comp,
        output in_comp, sum_dr, cout_dr, code_err
    );
endinterface

// File: rtl/dr_adder_pipe_fa_slice.sv
// One dual-rail full-adder bit: carry cell, sum-tree cell and sum register, one clock each;
// the sum register stalls while sum_comp disagrees. NULL play-ahead under NCL_NULL_PLAYAHEAD_EN.
module dr_fa_slice
    import ncl_pkg::*;
(
    input  logic clk,
    input  logic init,
    input  dr_t  a,
    input  dr_t  b,
    input  dr_t  cin,
    input  logic sum_comp,
    output dr_t  cout,
    output dr_t  sum
);
    dr_t  c_q;
    dr_t  ts_q;
    dr_t  s_q;
    dr_t  c_nxt;
    dr_t  ts_nxt;
    dr_t  s_nxt;
    logic ab_null;

    always_comb begin
`ifdef NCL_NULL_PLAYAHEAD_EN
        ab_null = (a == DR_NULL) && (b == DR_NULL);
`else
        ab_null = 1'b0;
`endif
        c_nxt[0]  = hyst(c_q[0], th23(a[0], b[0], cin[0]), ab_null | ~(a[0] | b[0] | cin[0]));
        c_nxt[1]  = hyst(c_q[1], th23(a[1], b[1], cin[1]), ab_null | ~(a[1] | b[1] | cin[1]));
        // Each sum rail is gated by the opposite carry-out rail, which keeps it from firing early.
        ts_nxt[0] = hyst(ts_q[0], th34w2(c_q[1], cin[0], b[0], a[0]),
                         ab_null | ~(c_q[1] | cin[0] | b[0] | a[0]));
        ts_nxt[1] = hyst(ts_q[1], th34w2(c_q[0], cin[1], b[1], a[1]),
                         ab_null | ~(c_q[0] | cin[1] | b[1] | a[1]));
        s_nxt[0]  = hyst(s_q[0], ts_q[0] & ~sum_comp, ~ts_q[0] & sum_comp);
        s_nxt[1]  = hyst(s_q[1], ts_q[1] & ~sum_comp, ~ts_q[1] & sum_comp);
    end

    always_ff @(posedge clk) begin
        if (init) begin
            c_q  <= DR_NULL;
            ts_q <= DR_NULL;
            s_q  <= DR_NULL;
        end else begin
            c_q  <= c_nxt;
            ts_q <= ts_nxt;
            s_q  <= s_nxt;
        end
    end

    assign cout = c_q;
    assign sum  = s_q;

endmodule

// File: rtl/dr_adder_pipe.sv
// WIDTH-bit clocked dual-rail ripple adder; DATA completes by edge WIDTH+3, acks stall the output
// registers without loss. NCL_NULL_PLAYAHEAD_EN makes the NULL wave a fixed 3 clocks.
module dr_adder_pipe
    import ncl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           init,
    dr_adder_pipe_if.slave bus
);
    dr_t                carry [WIDTH+1];
    logic [2*WIDTH-1:0] sum_w;
    logic [WIDTH-1:0]   dig_vld;
    dr_t                cout_q;
    dr_t                cout_nxt;
    logic               in_comp_q;
    logic               in_comp_nxt;
    logic               code_err_q;
    logic               illegal;
    logic               cout_vld;
    logic               all_data;
    logic               all_null;

    assign carry[0] = bus.cin_dr;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
        dr_fa_slice u_slice (
            .clk      (clk),
            .init     (init),
            .a        (bus.a_dr[2*gi +: 2]),
            .b        (bus.b_dr[2*gi +: 2]),
            .cin      (carry[gi]),
            .sum_comp (bus.sum_comp),
            .cout     (carry[gi+1]),
            .sum      (sum_w[2*gi +: 2])
        );
        assign dig_vld[gi] = |sum_w[2*gi +: 2];
    end

    always_comb begin
        cout_vld    = |cout_q;
        all_data    = (&dig_vld) & cout_vld;
        all_null    = ~(|dig_vld) & ~cout_vld;
        in_comp_nxt = hyst(in_comp_q, all_data, all_null);
        cout_nxt[0] = hyst(cout_q[0], carry[WIDTH][0] & ~bus.cout_comp, ~carry[WIDTH][0] & bus.cout_comp);
        cout_nxt[1] = hyst(cout_q[1], carry[WIDTH][1] & ~bus.cout_comp, ~carry[WIDTH][1] & bus.cout_comp);
        illegal     = is_illegal(bus.cin_dr);
        for (int i = 0; i < WIDTH; i++) begin
            illegal = illegal | is_illegal(bus.a_dr[2*i +: 2]) | is_illegal(bus.b_dr[2*i +: 2]);
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            cout_q     <= DR_NULL;
            in_comp_q  <= 1'b0;
            code_err_q <= 1'b0;
        end else begin
            cout_q     <= cout_nxt;
            in_comp_q  <= in_comp_nxt;
            code_err_q <= code_err_q | illegal;
        end
    end

    assign bus.sum_dr   = sum_w;
    assign bus.cout_dr  = cout_q;
    assign bus.in_comp  = in_comp_q;
    assign bus.code_err = code_err_q;

endmodule

// File: doc/dr_adder_pipe.md
Name: dr_adder_pipe

Overview:
- Parametrised clocked dual-rail (NCL DATA/NULL) ripple adder of WIDTH bits.
- Every threshold gate is a registered hysteresis cell, so the carry wavefront advances one bit per clock.
- Four-phase completion handshake on each side; sits between dual-rail operand registers and a dual-rail result consumer in the digit-pipelined adder chain.
- Adds over the single-bit full adder: width generalisation, a full-word completion tree, sticky illegal-code detection and optional NULL carry play-ahead.

Parameters:
- WIDTH, 8, number of bit slices (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- init  in  1  synchronous active-high reset.
- a_dr  in  2*WIDTH  operand A; bit i = {a_dr[2i+1] rail1, a_dr[2i] rail0}.
- b_dr  in  2*WIDTH  operand B, same encoding.
- cin_dr  in  2  carry-in, rail1/rail0.
- in_comp  out  1  completion to upstream; 1 = word DATA captured (request NULL), 0 = NULL captured (request DATA).
- sum_dr  out  2*WIDTH  dual-rail sum.
- sum_comp  in  1  downstream ack for sum; 1 = request NULL.
- cout_dr  out  2  dual-rail carry-out (= c[WIDTH]).
- cout_comp  in  1  downstream ack for carry-out.
- code_err  out  1  sticky; set when any input digit has both rails high.

Behaviour:
- Dual-rail code per digit: 00 NULL, 01 DATA0, 10 DATA1, 11 illegal.
- Hysteresis cell TH(m,n): q' = 1 if weighted count of ones >= m; 0 if all inputs 0; else hold q.
- Reset: when init=1 at an edge, every cell, sum_dr, cout_dr, in_comp and code_err go to 0 (all NULL). init overrides all other inputs, including mid-wavefront.
- c[0] = cin_dr (combinational).
- For i in 0..WIDTH-1, c[i+1].rail r = TH23(a_i.r, b_i.r, c[i].r), registered.
- ts_i.rail0 = TH34W2(c[i+1].rail1 weight 2, c[i].rail0, b_i.rail0, a_i.rail0), registered; rail1 is symmetric with the rails swapped.
- Sum register: sum_i.r = TH22(ts_i.r, ~sum_comp), registered. Goes DATA only while sum_comp=0; returns NULL only while sum_comp=1.
- cout_dr = TH22(c[WIDTH], ~cout_comp) per rail, registered.
- in_comp = C-element (TH-all hysteresis) over d_i = (sum_i.rail0 | sum_i.rail1) for all i, plus dv = (cout_dr.rail0 | cout_dr.rail1), registered.
  - Rises only when all sum bits and the carry-out are DATA.
  - Falls only when all are NULL.
- DATA latency, with inputs DATA from edge 0 and acks 0: c[k] DATA by edge k, sum_i by edge i+3, in_comp by edge WIDTH+3.
- NULL latency without play-ahead: the NULL wavefront also ripples, so in_comp falls by edge WIDTH+3 after inputs go NULL with acks 1.
- Upstream contract: inputs are held until in_comp toggles. The block never produces a DATA/NULL mix in captured sum_dr when inputs honour the contract.
- Illegal input (11) on a_dr, b_dr or cin_dr at any edge sets code_err=1 until init. Datapath behaviour on illegal input is undefined.
- Acks asserted early simply stall the sum/cout registers; no data loss.

Optional Feature:
- Macro: NCL_NULL_PLAYAHEAD_EN.
- Defined: each carry cell c[i+1] also clears to NULL when a_i and b_i are both NULL, regardless of c[i]. ts_i clears likewise. The NULL wavefront completes in a fixed 3 clocks independent of WIDTH.
- Undefined: pure TH23/TH34W2 hysteresis as above.
- DATA behaviour is identical in both builds.

Decomposition:
- Package ncl_pkg:
  - dual-rail typedef dr_t (logic [1:0]).
  - constants DR_NULL=2'b00, DR_0=2'b01, DR_1=2'b10.
  - functions is_data() and is_illegal().
- Sub-module dr_fa_slice: one bit, containing the carry cells, ts cells and sum register. Instantiated WIDTH times by generate.
- Completion tree and code_err live in the top.

Test Plan:
- Reset mid-wavefront: init pulsed at edge 2 of a DATA wave -> all outputs 0 at the next edge; code_err 0.
- WIDTH=8, A=0x5A, B=0x3C, cin=0, acks 0 -> sum=0x96, cout=0; in_comp=1 no later than edge 11.
- A=0xFF, B=0x01, cin=0 (full carry ripple) -> sum=0x00, cout=1; sum[7] DATA exactly at edge 10. Then all NULL with acks 1 -> in_comp=0 by edge 11 (default build) or edge 3 (NCL_NULL_PLAYAHEAD_EN).
- sum_comp held 1 during a DATA wave -> sum_dr stays NULL and in_comp stays 0. Release at edge 20 -> sum DATA at edge 21, in_comp=1 at edge 22.
- a_dr bit 3 driven 11 for one cycle -> code_err=1 from the next edge, persisting until init.
- 200 random legal four-phase transactions with random ack delays -> every captured sum equals A+B+cin, no mixed DATA/NULL words.
